param_register_file: RTL and testbench
======================================

Name:
param_register_file

Overview:
- Parametrised successor to the core's integer register file: DATA_WIDTH x 2^ADDR_WIDTH storage, two combinational read ports, one synchronous write port.
- Adds an optional hardwired-zero entry 0 and a reset-driven clear sequencer that zeroes every entry after reset.
- Adds a ready flag that holds off the pipeline until clearing finishes, plus an optional write-to-read bypass.
- Sits in the decode stage; writeback drives the write port.

Parameters:
DATA_WIDTH, 32, width of each register entry
ADDR_WIDTH, 5, index width; DEPTH = 2^ADDR_WIDTH entries
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
source1RegisterIndex  input  ADDR_WIDTH  read port 1 index
source2RegisterIndex  input  ADDR_WIDTH  read port 2 index
writeRegisterIndex  input  ADDR_WIDTH  write index
writeRegisterData  input  DATA_WIDTH  write data
shouldWrite  input  1  write enable
source1RegisterData  output  DATA_WIDTH  read port 1 data (combinational)
source2RegisterData  output  DATA_WIDTH  read port 2 data (combinational)
ready  output  1  high once clearing is complete; writes are accepted only while high

Behaviour:
- Reset values:
  - state = CLEAR, clearIndex = 0, ready = 0.
  - Read outputs are forced to 0 while in CLEAR.
- State machine, two states, CLEAR and READY:
  - While reset is high, the machine stays in CLEAR with clearIndex = 0 and no storage write.
  - In CLEAR with reset low, each edge writes 0 to entry clearIndex, then increments it.
  - When clearIndex == DEPTH-1 on that edge, the machine moves to READY and ready becomes 1.
  - Result: ready rises exactly DEPTH edges after reset deasserts. That is 32 for the defaults.
  - READY persists until reset.
- Reset mid-clear: the sequence restarts from entry 0; the full DEPTH edges are required again.
- Writes in CLEAR: shouldWrite is ignored and the write is dropped silently. The clear value wins.
- Writes in READY:
  - On a rising edge with shouldWrite=1, entry writeRegisterIndex <= writeRegisterData.
  - Exception: index 0 when ZERO_REG=1, which is a no-op.
- Reads:
  - Purely combinational from storage with no added latency. Without bypass, a write is visible the cycle after its edge.
  - Index 0 with ZERO_REG=1 always reads 0, including under bypass.
  - Both ports may address the same entry or the write entry simultaneously with no conflict.
- Width rules: indices are unsigned and span the full 0..DEPTH-1 range; there are no out-of-range indices. Data is stored unmodified.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - When in READY, shouldWrite=1 and readIndex == writeRegisterIndex, the read port returns writeRegisterData in the same cycle (write-through forwarding).
  - Suppressed for index 0 when ZERO_REG=1, and suppressed in CLEAR.
  - Applies independently to each port.
- Not defined: reads always return stored contents. The same-cycle read returns the old value; the new value appears the next cycle.

Test Plan:
- Reset high 2 cycles, then low -> ready=0 for edges 1..31 after deassert and 1 after edge 32. Reading indices 0..31 then returns 0x00000000 on both ports.
- After ready, write idx 5 = 0xDEADBEEF -> next cycle source1 (idx 5) = 0xDEADBEEF and source2 (idx 5) = 0xDEADBEEF.
- ZERO_REG=1: write idx 0 = 0x12345678 -> idx 0 reads 0x00000000 on both ports, with or without bypass. With ZERO_REG=0, the same write reads back 0x12345678 next cycle.
- idx 7 holds 0x00000001; in one cycle write idx 7 = 0xA5A5A5A5 while reading idx 7 on both ports:
  - With bypass, both ports read 0xA5A5A5A5 in that cycle.
  - Without bypass, both read 0x00000001 in that cycle and 0xA5A5A5A5 the next.
- Assert shouldWrite with idx 3 = 0xCAFEF00D on edge 2 of the clear sequence -> after ready, idx 3 reads 0x00000000.
- Pulse reset again on edge 10 of clearing -> ready stays 0 and rises exactly 32 edges after the second deassert.

Source files
------------

// File: rtl/param_register_file_if.sv
// Register-file access bundle: two read ports, one write port and the ready flag.
// The master drives indices and write data; the slave (the register file) drives read data and ready.
interface param_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] source1RegisterIndex;
    logic [ADDR_WIDTH-1:0] source2RegisterIndex;
    logic [ADDR_WIDTH-1:0] writeRegisterIndex;
    logic [DATA_WIDTH-1:0] writeRegisterData;
    logic                  shouldWrite;
    logic [DATA_WIDTH-1:0] source1RegisterData;
    logic [DATA_WIDTH-1:0] source2RegisterData;
    logic                  ready;

    modport master (
        output source1RegisterIndex, source2RegisterIndex,
        output writeRegisterIndex, writeRegisterData, shouldWrite,
        input  source1RegisterData, source2RegisterData, ready
    );

    modport slave (
        input  source1RegisterIndex, source2RegisterIndex,
        input  writeRegisterIndex, writeRegisterData, shouldWrite,
        output source1RegisterData, source2RegisterData, ready
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file with post-reset clear sequencer, ready flag and optional zero entry.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input logic                  clk,
    input logic                  reset,
    param_register_file_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_e;

    state_e                           state_q;
    logic [ADDR_WIDTH-1:0]            clear_idx_q;
    logic                             ready_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    // The clear sequencer owns the write port until READY; user writes are dropped meanwhile.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = rf.writeRegisterIndex;
        mem_wdata_d = rf.writeRegisterData;
        if (reset) begin
            mem_we_d = 1'b0;
        end else if (state_q == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clear_idx_q;
            mem_wdata_d = '0;
        end else begin
            mem_we_d = rf.shouldWrite &&
                       !((ZERO_REG != 0) && (rf.writeRegisterIndex == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clear_idx_q <= clear_idx_q + 1'b1;
                    if (clear_idx_q == LAST_IDX) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic                  fwd_hit,
        input logic [DATA_WIDTH-1:0] fwd_data
    );
        logic [DATA_WIDTH-1:0] d;
        d = mem_q[idx];
        if (fwd_hit) d = fwd_data;
        if ((state_q != READY) || ((ZERO_REG != 0) && (idx == '0))) d = '0;
        return d;
    endfunction

    logic fwd1, fwd2;

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        fwd1 = rf.shouldWrite && (rf.source1RegisterIndex == rf.writeRegisterIndex);
        fwd2 = rf.shouldWrite && (rf.source2RegisterIndex == rf.writeRegisterIndex);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
    end

    assign rf.source1RegisterData = read_port(rf.source1RegisterIndex, fwd1, rf.writeRegisterData);
    assign rf.source2RegisterData = read_port(rf.source2RegisterIndex, fwd2, rf.writeRegisterData);
    assign rf.ready               = ready_q;
endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: one ZERO_REG=1 and one ZERO_REG=0 instance on shared stimulus.
module tb_param_register_file;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifa ();
    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .rf(ifa));
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .rf(ifb));

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_a [32];
    logic [31:0] mdl_b [32];
    bit          mdl_rdy = 1'b0;
    int          clr_cnt = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] idx,
                                           input logic [4:0] widx, input logic [31:0] wd,
                                           input bit we, input logic [31:0] stored);
        if (!mdl_rdy) return 32'h0;
        if (zr && idx == 5'd0) return 32'h0;
        if (BYP && we && idx == widx) return wd;
        return stored;
    endfunction

    // One clock: drive inputs, score the combinational reads, clock, update model, score ready.
    task automatic cycle(input bit rst, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] widx, input logic [31:0] wd, input bit we);
        reset = rst;
        ifa.source1RegisterIndex = r1; ifb.source1RegisterIndex = r1;
        ifa.source2RegisterIndex = r2; ifb.source2RegisterIndex = r2;
        ifa.writeRegisterIndex = widx; ifb.writeRegisterIndex = widx;
        ifa.writeRegisterData = wd;    ifb.writeRegisterData = wd;
        ifa.shouldWrite = we;          ifb.shouldWrite = we;
        exp_q.push_back(exp_rd(1'b1, r1, widx, wd, we, mdl_a[r1])); tag_q.push_back("a.rd1");
        exp_q.push_back(exp_rd(1'b1, r2, widx, wd, we, mdl_a[r2])); tag_q.push_back("a.rd2");
        exp_q.push_back(exp_rd(1'b0, r1, widx, wd, we, mdl_b[r1])); tag_q.push_back("b.rd1");
        exp_q.push_back(exp_rd(1'b0, r2, widx, wd, we, mdl_b[r2])); tag_q.push_back("b.rd2");
        #1;
        chk(tag_q.pop_front(), ifa.source1RegisterData, exp_q.pop_front());
        chk(tag_q.pop_front(), ifa.source2RegisterData, exp_q.pop_front());
        chk(tag_q.pop_front(), ifb.source1RegisterData, exp_q.pop_front());
        chk(tag_q.pop_front(), ifb.source2RegisterData, exp_q.pop_front());
        @(posedge clk);
        if (rst) begin
            clr_cnt = 0;
            mdl_rdy = 1'b0;
        end else if (!mdl_rdy) begin
            clr_cnt++;
            if (clr_cnt == 32) begin
                mdl_rdy = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    mdl_a[i] = 32'h0;
                    mdl_b[i] = 32'h0;
                end
            end
        end else if (we) begin
            if (widx != 5'd0) mdl_a[widx] = wd;
            mdl_b[widx] = wd;
        end
        #1;
        chk("a.ready", {31'b0, ifa.ready}, {31'b0, mdl_rdy});
        chk("b.ready", {31'b0, ifb.ready}, {31'b0, mdl_rdy});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mdl_a[i] = 32'h0;
            mdl_b[i] = 32'h0;
        end
        reset = 1'b1;
        ifa.source1RegisterIndex = '0; ifb.source1RegisterIndex = '0;
        ifa.source2RegisterIndex = '0; ifb.source2RegisterIndex = '0;
        ifa.writeRegisterIndex = '0;   ifb.writeRegisterIndex = '0;
        ifa.writeRegisterData = '0;    ifb.writeRegisterData = '0;
        ifa.shouldWrite = 1'b0;        ifb.shouldWrite = 1'b0;
        @(posedge clk); #1;

        // Reset held two cycles, then a clear aborted by a reset pulse on edge 10.
        cycle(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        cycle(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        for (int k = 1; k <= 9; k++) cycle(1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
        cycle(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        // Full clear; a write to idx 3 on edge 2 must be dropped.
        for (int k = 1; k <= 32; k++) begin
            if (k == 2) cycle(1'b0, 5'd3, 5'd3, 5'd3, 32'hCAFEF00D, 1'b1);
            else        cycle(1'b0, 5'd0, 5'd31, 5'd0, 32'h0, 1'b0);
        end

        for (int i = 0; i < 32; i++) cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);

        cycle(1'b0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 1'b1);
        cycle(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'h12345678, 1'b1);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        cycle(1'b0, 5'd1, 5'd2, 5'd7, 32'h00000001, 1'b1);
        cycle(1'b0, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 1'b1);
        cycle(1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0);
        cycle(1'b0, 5'd3, 5'd5, 5'd0, 32'h0, 1'b0);

        for (int k = 0; k < 40; k++)
            cycle(1'b0, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
